// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - Instruction prefetch queue between instruction memory and IF/ID
//
// Fetches sequential instruction words ahead of the pipeline over a single
// outstanding req/ack handshake and buffers up to DEPTH {pc, ir} pairs. The
// oldest pair is presented to IF/ID, held while stalled, and the whole queue
// is discarded on a redirect.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset (priority over redirect)
//   i_redirect     PC change this cycle; flushes the queue
//   i_redirect_pc  new fetch address, bits [1:0] forced to zero
//   i_stall        head entry is not consumed this cycle
//   o_valid        head entry present
//   o_ir           head instruction word (0 when !o_valid)
//   o_pc_out       head instruction address (0 when !o_valid)
//   o_mem_req      fetch request to instruction memory
//   o_mem_addr     word-aligned fetch address, equal to the fetch pc
//   i_mem_ack      fetch complete, qualifies i_mem_rdata
//   i_mem_rdata    fetched instruction word
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_valid,
    output logic [31:0] o_ir,
    output logic [31:0] o_pc_out,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FULL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_next;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_pc_mem [DEPTH];
    logic [31:0]    r_ir_mem [DEPTH];

    logic           w_mem_req;
    logic           w_push;
    logic           w_pop;
    logic [31:0]    w_redirect_pc;

    assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;

    // Request only in RUN; suppressed during the reset cycle so the memory
    // never sees a request whose response would be thrown away.
    assign w_mem_req = (r_state == ST_RUN) && !i_rst;

    // An ack in the redirect cycle belongs to the old stream and is dropped.
    assign w_push = w_mem_req && i_mem_ack && !i_redirect;
    assign w_pop  = o_valid && !i_stall && !i_redirect;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Next state looks at the post-update count so that a freeing pop puts
    // the request back on the bus in the very next cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_push && (w_count_next == DEPTH_C)) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_count_next < DEPTH_C) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
        if (i_redirect) begin
            w_state_next = ST_FLUSH;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_state    <= ST_FLUSH;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= w_redirect_pc;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Entry storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr] <= r_fetch_pc;
            r_ir_mem[r_wr_ptr] <= i_mem_rdata;
        end
    end

    assign o_valid    = (r_count != '0);
    assign o_ir       = o_valid ? r_ir_mem[r_rd_ptr] : 32'd0;
    assign o_pc_out   = o_valid ? r_pc_mem[r_rd_ptr] : 32'd0;
    assign o_mem_req  = w_mem_req;
    assign o_mem_addr = r_fetch_pc;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - Directed self-checking bench for inst_prefetch_queue
module tb_inst_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int ws = 0;
    int wait_cnt = 0;

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_stall       (stall),
        .o_valid       (valid),
        .o_ir          (ir),
        .o_pc_out      (pc_out),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_ack     (mem_ack),
        .i_mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    // Memory with ws wait states: ack after the request has been held ws cycles.
    assign mem_ack   = mem_req && (wait_cnt == ws);
    assign mem_rdata = instr_of(mem_addr);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        redirect = 1'b0;
        stall = 1'b0;
        redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (ir !== 32'd0) begin errors++; $display("FAIL reset_ir got %h want 0", ir); end
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin errors++; $display("FAIL reset_release_req got %0b/%h want 1/0", mem_req, mem_addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %0b want 0", valid); end
    endtask

    task automatic test_stream;
        ws = 0;
        stall = 1'b0;
        do_reset();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0 || valid !== 1'b0) begin errors++; $display("FAIL stream_c0 got req=%0b addr=%h valid=%0b want 1/0/0", mem_req, mem_addr, valid); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (valid !== 1'b1 || pc_out !== 32'(4*k)) begin errors++; $display("FAIL stream_head k=%0d got valid=%0b pc=%h want 1/%h", k, valid, pc_out, 32'(4*k)); end
            checks++; if (ir !== instr_of(32'(4*k))) begin errors++; $display("FAIL stream_ir k=%0d got %h want %h", k, ir, instr_of(32'(4*k))); end
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4*(k+1))) begin errors++; $display("FAIL stream_addr k=%0d got req=%0b addr=%h want 1/%h", k, mem_req, mem_addr, 32'(4*(k+1))); end
        end
    endtask

    task automatic test_stall;
        int pushes;
        int idle;
        ws = 0;
        stall = 1'b1;
        do_reset();
        pushes = 0;
        idle = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req && mem_ack) pushes++;
            if (i >= 4 && !mem_req) idle++;
            step();
        end
        checks++; if (pushes !== 4) begin errors++; $display("FAIL stall_pushes got %0d want 4", pushes); end
        checks++; if (idle !== 6) begin errors++; $display("FAIL stall_req_low_cycles got %0d want 6", idle); end
        checks++; if (valid !== 1'b1 || pc_out !== 32'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL stall_hold got valid=%0b pc=%h req=%0b want 1/0/0", valid, pc_out, mem_req); end
        stall = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_release_req_early got %0b want 0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd16 || pc_out !== 32'd4) begin errors++; $display("FAIL stall_release got req=%0b addr=%h pc=%h want 1/10/4", mem_req, mem_addr, pc_out); end
        for (int k = 2; k <= 4; k++) begin
            step();
            checks++; if (valid !== 1'b1 || pc_out !== 32'(4*k)) begin errors++; $display("FAIL stall_drain k=%0d got pc=%h want %h", k, pc_out, 32'(4*k)); end
        end
    endtask

    task automatic test_redirect;
        ws = 0;
        stall = 1'b1;
        do_reset();
        repeat (3) step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd12 || pc_out !== 32'd0) begin errors++; $display("FAIL redir_pre got req=%0b addr=%h pc=%h want 1/c/0", mem_req, mem_addr, pc_out); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(posedge clk);
        #1 redirect = 1'b0;
        stall = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL redir_flush got valid=%0b req=%0b want 0/0", valid, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || valid !== 1'b0) begin errors++; $display("FAIL redir_newreq got req=%0b addr=%h valid=%0b want 1/100/0", mem_req, mem_addr, valid); end
        step();
        checks++; if (valid !== 1'b1 || pc_out !== 32'h100 || ir !== instr_of(32'h100)) begin errors++; $display("FAIL redir_first got valid=%0b pc=%h ir=%h want 1/100/%h", valid, pc_out, ir, instr_of(32'h100)); end
        step();
        checks++; if (valid !== 1'b1 || pc_out !== 32'h104) begin errors++; $display("FAIL redir_second got valid=%0b pc=%h want 1/104", valid, pc_out); end
    endtask

    task automatic test_wait_states;
        int popped;
        ws = 2;
        stall = 1'b0;
        do_reset();
        popped = 0;
        for (int c = 0; c < 25; c++) begin
            if (c < 24) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4*(c/3))) begin errors++; $display("FAIL wait_addr c=%0d got req=%0b addr=%h want 1/%h", c, mem_req, mem_addr, 32'(4*(c/3))); end
            end
            if (valid) begin
                checks++; if (pc_out !== 32'(4*popped) || ir !== instr_of(32'(4*popped))) begin errors++; $display("FAIL wait_order n=%0d got pc=%h ir=%h want %h", popped, pc_out, ir, 32'(4*popped)); end
                popped++;
            end
            step();
        end
        checks++; if (popped !== 8) begin errors++; $display("FAIL wait_count got %0d want 8", popped); end
        ws = 0;
    endtask

    task automatic test_push_pop_wrap;
        ws = 0;
        stall = 1'b1;
        do_reset();
        repeat (3) step();
        stall = 1'b0;
        #1;
        for (int k = 0; k < 12; k++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4*(k+3))) begin errors++; $display("FAIL wrap_req k=%0d got req=%0b addr=%h want 1/%h", k, mem_req, mem_addr, 32'(4*(k+3))); end
            checks++; if (valid !== 1'b1 || pc_out !== 32'(4*k) || ir !== instr_of(32'(4*k))) begin errors++; $display("FAIL wrap_head k=%0d got pc=%h ir=%h want %h", k, pc_out, ir, 32'(4*k)); end
            step();
        end
    endtask

    task automatic test_rst_redirect;
        ws = 0;
        stall = 1'b0;
        do_reset();
        repeat (5) step();
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstredir_req got %0b want 0", mem_req); end
        @(posedge clk);
        #1 rst = 1'b0;
        redirect = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'd0) begin errors++; $display("FAIL rstredir_restart got valid=%0b req=%0b addr=%h want 0/1/0", valid, mem_req, mem_addr); end
        step();
        checks++; if (valid !== 1'b1 || pc_out !== 32'd0) begin errors++; $display("FAIL rstredir_first got valid=%0b pc=%h want 1/0", valid, pc_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wait_states();
        test_push_pop_wrap();
        test_rst_redirect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
